// File: rtl/lowx_mem_responder_pkg.sv
// Shared types for the lower-level memory responder: L1 miss request/response
// structs, the memory-side interface, and the responder state/port enums.
package lowx_mem_responder_pkg;

  localparam int BLK_SIZE  = 128;
  localparam int XLEN      = 32;
  localparam int BLK_BYTES = BLK_SIZE / 8;

  typedef enum logic [1:0] {NO_SIZE, BYTE, HALF_WORD, WORD} rw_size_e;

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] addr;
    logic            uncached;
  } ilowX_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] blk;
  } ilowX_res_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [XLEN-1:0]     addr;
    rw_size_e            rw_size;
    logic                rw;
    logic [BLK_SIZE-1:0] data;
    logic                uncached;
  } dlowX_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] data;
  } dlowX_res_t;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      addr;
    logic [BLK_SIZE-1:0]  data;
    logic [BLK_BYTES-1:0] rw;
  } mem_req_t;

  typedef struct packed {
    logic                valid;
    logic [BLK_SIZE-1:0] data;
  } mem_res_t;

  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, RESP} lowx_state_e;
  typedef enum logic {PORT_I, PORT_D} lowx_port_e;

  function automatic logic [XLEN-1:0] blk_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:4], 4'b0000};
  endfunction

endpackage

// File: rtl/lowx_wstrb_gen.sv
// Byte-strobe and lane placement for D-side writes. A line writeback passes the
// whole block through; sized writes move the right-aligned value into its lanes.
module lowx_wstrb_gen
  import lowx_mem_responder_pkg::*;
(
  input  logic [3:0]           addr_lo,
  input  rw_size_e             rw_size,
  input  logic [BLK_SIZE-1:0]  data,
  output logic [BLK_BYTES-1:0] strb,
  output logic [BLK_SIZE-1:0]  wdata
);

  logic [31:0]         value;
  logic [BLK_SIZE-1:0] value_ext;

  always_comb begin
    strb  = '0;
    value = '0;
    case (rw_size)
      BYTE: begin
        strb  = 16'h0001 << addr_lo;
        value = {24'h0, data[7:0]};
      end
      HALF_WORD: begin
        strb  = 16'h0003 << {addr_lo[3:1], 1'b0};
        value = {16'h0, data[15:0]};
      end
      WORD: begin
        strb  = 16'h000F << {addr_lo[3:2], 2'b00};
        value = data[31:0];
      end
      default: strb = '1;
    endcase
  end

  // Unused upper bits of the value are masked so only the written lanes carry data.
  assign value_ext = {{(BLK_SIZE-32){1'b0}}, value};
  assign wdata     = (rw_size == NO_SIZE) ? data : (value_ext << {addr_lo, 3'b000});

endmodule

// File: rtl/lowx_mem_responder.sv
// Round-robin responder for I/D cache misses: one block-aligned memory request
// per accepted miss, block returned to the granted port.
module lowx_mem_responder
  import lowx_mem_responder_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  ilowX_req_t ilowx_req_i,
  output ilowX_res_t ilowx_res_o,
  input  dlowX_req_t dlowx_req_i,
  output dlowX_res_t dlowx_res_o,
  output mem_req_t   mem_req_o,
  input  mem_res_t   mem_res_i
);

  lowx_state_e          state_q;
  lowx_port_e           last_grant_q;
  lowx_port_e           port_q;
  logic                 rw_q;
  logic                 uncached_q;
  logic                 i_vld_q;
  logic                 d_vld_q;
  logic [BLK_SIZE-1:0]  resp_blk_q;
  mem_req_t             mem_req_q;

  logic                 in_idle;
  logic                 grant_i;
  logic                 grant_d;
  logic                 blk_arrives;
  logic                 resp_taken;
  logic [BLK_BYTES-1:0] wstrb;
  logic [BLK_SIZE-1:0]  wdata;
  logic                 unused_uncached;

  // Ready is held low while reset is asserted, even if requests are already valid.
  assign in_idle     = rst_ni & (state_q == IDLE);
  assign grant_i     = in_idle & ilowx_req_i.valid & (~dlowx_req_i.valid | (last_grant_q == PORT_D));
  assign grant_d     = in_idle & dlowx_req_i.valid & (~ilowx_req_i.valid | (last_grant_q == PORT_I));
  assign blk_arrives = mem_res_i.valid & ((state_q == MEM_REQ) | (state_q == MEM_WAIT));
  assign resp_taken  = (port_q == PORT_I) ? ilowx_req_i.ready : dlowx_req_i.ready;

  // Uncached misses still fetch a full block; the flag has no effect here.
  assign unused_uncached = uncached_q;

  lowx_wstrb_gen u_wstrb_gen (
    .addr_lo (dlowx_req_i.addr[3:0]),
    .rw_size (dlowx_req_i.rw_size),
    .data    (dlowx_req_i.data),
    .strb    (wstrb),
    .wdata   (wdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_I;
      port_q       <= PORT_I;
      rw_q         <= 1'b0;
      uncached_q   <= 1'b0;
      i_vld_q      <= 1'b0;
      d_vld_q      <= 1'b0;
      resp_blk_q   <= '0;
      mem_req_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            port_q         <= PORT_D;
            last_grant_q   <= PORT_D;
            rw_q           <= dlowx_req_i.rw;
            uncached_q     <= dlowx_req_i.uncached;
            mem_req_q.valid <= 1'b1;
            mem_req_q.addr  <= blk_align(dlowx_req_i.addr);
            mem_req_q.rw    <= dlowx_req_i.rw ? wstrb : '0;
            mem_req_q.data  <= dlowx_req_i.rw ? wdata : '0;
            state_q        <= MEM_REQ;
          end else if (grant_i) begin
            port_q         <= PORT_I;
            last_grant_q   <= PORT_I;
            rw_q           <= 1'b0;
            uncached_q     <= ilowx_req_i.uncached;
            mem_req_q.valid <= 1'b1;
            mem_req_q.addr  <= blk_align(ilowx_req_i.addr);
            mem_req_q.rw    <= '0;
            mem_req_q.data  <= '0;
            state_q        <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          mem_req_q <= '0;
          state_q   <= blk_arrives ? RESP : MEM_WAIT;
        end
        MEM_WAIT: begin
          if (blk_arrives) state_q <= RESP;
        end
        RESP: begin
          if (resp_taken) begin
            i_vld_q <= 1'b0;
            d_vld_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A block can land in MEM_REQ or MEM_WAIT; writes answer with zero data.
      if (blk_arrives) begin
        resp_blk_q <= rw_q ? '0 : mem_res_i.data;
        i_vld_q    <= (port_q == PORT_I);
        d_vld_q    <= (port_q == PORT_D);
      end
    end
  end

  always_comb begin
    ilowx_res_o       = '0;
    ilowx_res_o.ready = grant_i;
    ilowx_res_o.valid = i_vld_q;
    ilowx_res_o.blk   = i_vld_q ? resp_blk_q : '0;
    dlowx_res_o       = '0;
    dlowx_res_o.ready = grant_d;
    dlowx_res_o.valid = d_vld_q;
    dlowx_res_o.data  = d_vld_q ? resp_blk_q : '0;
  end

  assign mem_req_o = mem_req_q;

endmodule

// File: tb/tb_lowx_mem_responder.sv
// Self-checking bench for lowx_mem_responder with a behavioural reference model.
module tb_lowx_mem_responder;
  import lowx_mem_responder_pkg::*;

  logic       clk;
  logic       rst_ni;
  ilowX_req_t ireq;
  ilowX_res_t ires;
  dlowX_req_t dreq;
  dlowX_res_t dres;
  mem_req_t   mreq_o;
  mem_res_t   mres;

  int total = 0;
  int bad   = 0;

  lowx_mem_responder dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .ilowx_req_i (ireq),
    .ilowx_res_o (ires),
    .dlowx_req_i (dreq),
    .dlowx_res_o (dres),
    .mem_req_o   (mreq_o),
    .mem_res_i   (mres)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: strobe and lane data expected on the memory side.
  function automatic logic [15:0] exp_strb(input logic wr, input rw_size_e sz, input logic [31:0] a);
    int lo;
    lo = int'(a[3:0]);
    if (!wr) return 16'h0000;
    case (sz)
      NO_SIZE:   return 16'hFFFF;
      BYTE:      return 16'(1 << lo);
      HALF_WORD: return 16'(3 << ((lo / 2) * 2));
      default:   return 16'(15 << ((lo / 4) * 4));
    endcase
  endfunction

  function automatic logic [127:0] exp_wdata(input rw_size_e sz, input logic [31:0] a, input logic [127:0] d);
    logic [127:0] v;
    int lo;
    lo = int'(a[3:0]);
    case (sz)
      NO_SIZE:   return d;
      BYTE:      v = 128'(d[7:0]);
      HALF_WORD: v = 128'(d[15:0]);
      default:   v = 128'(d[31:0]);
    endcase
    return v << (lo * 8);
  endfunction

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic apply_reset();
    rst_ni = 1'b0;
    ireq = '0;
    dreq = '0;
    mres = '0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Drives one single-port transaction and reports what the DUT produced.
  task automatic run_txn(input bit is_d, input logic [31:0] addr, input bit wr, input rw_size_e sz,
                         input logic [127:0] wd, input int dly, input logic [127:0] blk,
                         output mem_req_t seen, output logic [127:0] rdata,
                         output int req_lat, output int res_lat);
    int n;
    @(negedge clk);
    if (is_d) begin
      dreq.valid = 1'b1; dreq.ready = 1'b1; dreq.addr = addr;
      dreq.rw = wr; dreq.rw_size = sz; dreq.data = wd; dreq.uncached = $urandom_range(0, 1);
    end else begin
      ireq.valid = 1'b1; ireq.ready = 1'b1; ireq.addr = addr; ireq.uncached = $urandom_range(0, 1);
    end
    n = 0;
    #1;
    while (!(is_d ? dres.ready : ires.ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    ireq.valid = 1'b0; dreq.valid = 1'b0;
    ireq.addr = $urandom; dreq.addr = $urandom; dreq.data = rand_blk();
    n = 1;
    while (!mreq_o.valid && n < 20) begin
      @(negedge clk); n++;
    end
    req_lat = n;
    seen = mreq_o;
    for (int k = 0; k < dly; k++) @(negedge clk);
    mres.valid = 1'b1; mres.data = blk;
    @(negedge clk);
    mres.valid = 1'b0; mres.data = rand_blk();
    n = 1;
    while (!(is_d ? dres.valid : ires.valid) && n < 20) begin
      @(negedge clk); n++;
    end
    res_lat = n;
    rdata = is_d ? dres.data : ires.blk;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    ireq = '0; dreq = '0; mres = '0;
    ireq.valid = 1'b1; dreq.valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (ires !== '0) begin bad++; $display("FAIL reset_ires got=%h exp=0", ires); end
    total++; if (dres !== '0) begin bad++; $display("FAIL reset_dres got=%h exp=0", dres); end
    total++; if (mreq_o !== '0) begin bad++; $display("FAIL reset_mem_req got=%h exp=0", mreq_o); end
    ireq.valid = 1'b0; dreq.valid = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_i_read();
    mem_req_t seen; logic [127:0] rd, b; int rl, sl;
    b = rand_blk();
    run_txn(1'b0, 32'h0000_1234, 1'b0, NO_SIZE, '0, 3, b, seen, rd, rl, sl);
    total++; if (seen.addr !== 32'h0000_1230) begin bad++; $display("FAIL iread_addr got=%h exp=00001230", seen.addr); end
    total++; if (seen.rw !== 16'h0000) begin bad++; $display("FAIL iread_rw got=%h exp=0000", seen.rw); end
    total++; if (rl !== 1) begin bad++; $display("FAIL iread_req_latency got=%0d exp=1", rl); end
    total++; if (sl !== 1) begin bad++; $display("FAIL iread_res_latency got=%0d exp=1", sl); end
    total++; if (rd !== b) begin bad++; $display("FAIL iread_blk got=%h exp=%h", rd, b); end
    total++; if (ires.valid !== 1'b0) begin bad++; $display("FAIL iread_release got=%b exp=0", ires.valid); end
  endtask

  task automatic test_tie_arbitration();
    bit exp_d;
    apply_reset();
    exp_d = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ireq.valid = 1'b1; ireq.ready = 1'b1; ireq.addr = $urandom;
      dreq.valid = 1'b1; dreq.ready = 1'b1; dreq.addr = $urandom; dreq.rw = 1'b0;
      #1;
      total++; if (dres.ready !== exp_d) begin bad++; $display("FAIL tie_d_ready[%0d] got=%b exp=%b", k, dres.ready, exp_d); end
      total++; if (ires.ready !== !exp_d) begin bad++; $display("FAIL tie_i_ready[%0d] got=%b exp=%b", k, ires.ready, !exp_d); end
      @(negedge clk);
      ireq.valid = 1'b0; dreq.valid = 1'b0;
      mres.valid = 1'b1; mres.data = rand_blk();
      @(negedge clk);
      mres.valid = 1'b0;
      total++; if (dres.valid !== exp_d) begin bad++; $display("FAIL tie_d_valid[%0d] got=%b exp=%b", k, dres.valid, exp_d); end
      total++; if (ires.valid !== !exp_d) begin bad++; $display("FAIL tie_i_valid[%0d] got=%b exp=%b", k, ires.valid, !exp_d); end
      exp_d = !exp_d;
    end
    @(negedge clk);
  endtask

  task automatic test_sized_writes();
    logic [31:0]  addrs [3];
    rw_size_e     sizes [3];
    logic [15:0]  strbs [3];
    logic [127:0] wd, rd, ew;
    mem_req_t seen; int rl, sl;
    addrs[0] = 32'h2000_0003; sizes[0] = BYTE;      strbs[0] = 16'h0008;
    addrs[1] = 32'h2000_0006; sizes[1] = HALF_WORD; strbs[1] = 16'h00C0;
    addrs[2] = 32'h2000_000C; sizes[2] = WORD;      strbs[2] = 16'hF000;
    for (int k = 0; k < 3; k++) begin
      wd = (k == 0) ? 128'hAB : rand_blk();
      ew = exp_wdata(sizes[k], addrs[k], wd);
      run_txn(1'b1, addrs[k], 1'b1, sizes[k], wd, k, rand_blk(), seen, rd, rl, sl);
      total++; if (seen.rw !== strbs[k]) begin bad++; $display("FAIL sized_strb[%0d] got=%h exp=%h", k, seen.rw, strbs[k]); end
      total++; if (seen.data !== ew) begin bad++; $display("FAIL sized_data[%0d] got=%h exp=%h", k, seen.data, ew); end
      total++; if (seen.addr !== 32'h2000_0000) begin bad++; $display("FAIL sized_addr[%0d] got=%h exp=20000000", k, seen.addr); end
      total++; if (rd !== '0) begin bad++; $display("FAIL sized_resp[%0d] got=%h exp=0", k, rd); end
    end
    total++; if (ew !== 128'h0) ; else begin bad++; $display("FAIL sized_model got=0 exp=nonzero"); end
  endtask

  task automatic test_writeback();
    logic [127:0] wd, rd; logic [31:0] a; mem_req_t seen; int rl, sl;
    wd = rand_blk(); a = $urandom;
    run_txn(1'b1, a, 1'b1, NO_SIZE, wd, 1, rand_blk(), seen, rd, rl, sl);
    total++; if (seen.rw !== 16'hFFFF) begin bad++; $display("FAIL wb_strb got=%h exp=ffff", seen.rw); end
    total++; if (seen.data !== wd) begin bad++; $display("FAIL wb_data got=%h exp=%h", seen.data, wd); end
    total++; if (seen.addr !== {a[31:4], 4'h0}) begin bad++; $display("FAIL wb_addr got=%h exp=%h", seen.addr, {a[31:4], 4'h0}); end
    total++; if (rd !== '0) begin bad++; $display("FAIL wb_resp got=%h exp=0", rd); end
  endtask

  task automatic test_hold();
    logic [127:0] b;
    b = rand_blk();
    @(negedge clk);
    dreq.valid = 1'b1; dreq.ready = 1'b0; dreq.rw = 1'b0; dreq.addr = $urandom;
    ireq.valid = 1'b0;
    @(negedge clk);
    dreq.valid = 1'b0;
    mres.valid = 1'b1; mres.data = b;
    @(negedge clk);
    mres.valid = 1'b0;
    ireq.valid = 1'b1; dreq.valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (dres.valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%b exp=1", k, dres.valid); end
      total++; if (dres.data !== b) begin bad++; $display("FAIL hold_data[%0d] got=%h exp=%h", k, dres.data, b); end
      total++; if ({ires.ready, dres.ready} !== 2'b00) begin bad++; $display("FAIL hold_ready[%0d] got=%b exp=00", k, {ires.ready, dres.ready}); end
      total++; if (mreq_o.valid !== 1'b0) begin bad++; $display("FAIL hold_memreq[%0d] got=%b exp=0", k, mreq_o.valid); end
      total++; if (ires.valid !== 1'b0) begin bad++; $display("FAIL hold_other_valid[%0d] got=%b exp=0", k, ires.valid); end
      @(negedge clk);
    end
    ireq.valid = 1'b0; dreq.valid = 1'b0; dreq.ready = 1'b1;
    @(negedge clk);
    total++; if (dres.valid !== 1'b0) begin bad++; $display("FAIL hold_release got=%b exp=0", dres.valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ireq.valid = 1'b1; ireq.ready = 1'b1; ireq.addr = $urandom;
    @(negedge clk);
    ireq.valid = 1'b0;
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    total++; if (mreq_o !== '0) begin bad++; $display("FAIL rstmid_mem_req got=%h exp=0", mreq_o); end
    total++; if (ires !== '0) begin bad++; $display("FAIL rstmid_ires got=%h exp=0", ires); end
    total++; if (dres !== '0) begin bad++; $display("FAIL rstmid_dres got=%h exp=0", dres); end
    @(negedge clk);
    rst_ni = 1'b1;
    mres.valid = 1'b1; mres.data = rand_blk();
    @(negedge clk);
    mres.valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if ({ires.valid, dres.valid} !== 2'b00) begin bad++; $display("FAIL rstmid_late_res[%0d] got=%b exp=00", k, {ires.valid, dres.valid}); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    mem_req_t seen; logic [127:0] rd, wd, b; logic [31:0] a;
    bit is_d, wr; rw_size_e sz; int dly, rl, sl;
    for (int k = 0; k < 40; k++) begin
      is_d = $urandom_range(0, 1);
      wr   = is_d && $urandom_range(0, 1);
      sz   = rw_size_e'($urandom_range(0, 3));
      a    = $urandom;
      wd   = rand_blk();
      b    = rand_blk();
      dly  = $urandom_range(0, 4);
      run_txn(is_d, a, wr, sz, wd, dly, b, seen, rd, rl, sl);
      total++; if (seen.addr !== {a[31:4], 4'h0}) begin bad++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", k, seen.addr, {a[31:4], 4'h0}); end
      total++; if (seen.rw !== exp_strb(wr, sz, a)) begin bad++; $display("FAIL rnd_strb[%0d] got=%h exp=%h", k, seen.rw, exp_strb(wr, sz, a)); end
      if (wr) begin
        total++; if (seen.data !== exp_wdata(sz, a, wd)) begin bad++; $display("FAIL rnd_wdata[%0d] got=%h exp=%h", k, seen.data, exp_wdata(sz, a, wd)); end
      end
      total++; if (rl !== 1) begin bad++; $display("FAIL rnd_req_latency[%0d] got=%0d exp=1", k, rl); end
      total++; if (sl !== 1) begin bad++; $display("FAIL rnd_res_latency[%0d] got=%0d exp=1", k, sl); end
      total++; if (rd !== (wr ? 128'h0 : b)) begin bad++; $display("FAIL rnd_resp[%0d] got=%h exp=%h", k, rd, (wr ? 128'h0 : b)); end
      total++; if ({ires.valid, dres.valid} !== 2'b00) begin bad++; $display("FAIL rnd_release[%0d] got=%b exp=00", k, {ires.valid, dres.valid}); end
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_tie_arbitration();
    test_sized_writes();
    test_writeback();
    test_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
